// File: rtl/hasti_to_poci_bridge.sv
// hasti_to_poci_bridge: AHB-Lite slave to APB master bridge with a PREADY watchdog.
module hasti_to_poci_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic [31:0]           hwdata,
    input  logic                  hsel,
    input  logic                  hready,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);
    localparam int WW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
    state_t state;
    logic [WW-1:0] wdog;
    logic accept, bad_size, timeout, ok;
    assign accept   = hsel && hready && (htrans == 2'b10 || htrans == 2'b11) &&
                      (state == IDLE || state == DONE || state == ERR2);
    assign bad_size = hwrite && hsize != 3'b010;
    assign timeout  = TIMEOUT_CYCLES != 0 && wdog == WW'(TIMEOUT_CYCLES - 1);
    assign ok       = pready && !pslverr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            hrdata    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            wdog      <= '0;
        end else begin
            case (state)
                LATCH: begin
                    if (pwrite) pwdata <= hwdata;
                    wdog  <= '0;
                    psel  <= 1'b1;
                    state <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout landing in the same cycle
                    if (pready || timeout) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        hreadyout <= ok;
                        hresp     <= !ok;
                        state     <= ok ? DONE : ERR1;
                        if (ok && !pwrite) hrdata <= prdata;
                    end else if (!(&wdog)) wdog <= wdog + 1'b1;
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                default: begin
                    hreadyout <= !accept;
                    hresp     <= accept && bad_size;
                    state     <= !accept ? IDLE : bad_size ? ERR1 : LATCH;
                    if (accept) begin
                        paddr  <= haddr[ADDR_WIDTH-1:0];
                        pwrite <= hwrite;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hasti_to_poci_bridge.sv
// tb_hasti_to_poci_bridge: directed checks of the AHB-to-APB bridge with a 4-cycle watchdog.
module tb_hasti_to_poci_bridge;
    logic clk = 0, reset = 1;
    logic [31:0] haddr = 0, hwdata = 0, prdata = 0, hrdata, pwdata;
    logic [31:0] paddr;
    logic [2:0] hsize = 3'b010;
    logic [1:0] htrans = 0;
    logic hwrite = 0, hsel = 0, hready, hreadyout, hresp, pwrite, psel, penable;
    logic pready = 0, pslverr = 0;
    int tests = 0, fails = 0;

    assign hready = hreadyout;
    always #5 clk = ~clk;

    hasti_to_poci_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
        .hwdata(hwdata), .hsel(hsel), .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout),
        .hresp(hresp), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Issues one AHB transfer from a ready cycle and acts as APB slave until hreadyout returns high.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input int waits, input logic err, output int lows, output int setups,
                        output int accs, output int setup_at, output logic err_lo, output logic bad_apb);
        int n;
        lows = 0; setups = 0; accs = 0; setup_at = -1; err_lo = 0; bad_apb = 0;
        haddr = a; hwrite = w; hsize = sz; htrans = 2'b10; hsel = 1; pready = 0; pslverr = err;
        @(posedge clk); #1;
        hsel = 0; htrans = 0; hwdata = wd;
        n = 1;
        while (!hreadyout && n < 60) begin
            lows++;
            if (hresp) err_lo = 1;
            if (psel && !penable) begin setups++; if (setup_at < 0) setup_at = n; end
            if (psel && penable) accs++;
            if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== wd) || hresp)) bad_apb = 1;
            pready = psel && penable && accs > waits;
            @(posedge clk); #1; n++;
        end
        pready = 0;
        if (!hreadyout) begin tests++; fails++; $display("FAIL xfer_bound: hreadyout still low for addr %h, required high", a); end
    endtask

    task automatic test_reset();
        tests++; if (hreadyout !== 1'b1) begin fails++; $display("FAIL rst_hreadyout: got %b want 1", hreadyout); end
        tests++; if (hresp !== 1'b0) begin fails++; $display("FAIL rst_hresp: got %b want 0", hresp); end
        tests++; if ({psel, penable, pwrite} !== 3'b000) begin fails++; $display("FAIL rst_apb_ctrl: got %b want 000", {psel, penable, pwrite}); end
        tests++; if (paddr !== 32'h0 || pwdata !== 32'h0 || hrdata !== 32'h0) begin fails++; $display("FAIL rst_data: paddr %h pwdata %h hrdata %h want 0", paddr, pwdata, hrdata); end
    endtask

    task automatic test_idle_transfers();
        logic seen;
        seen = 0;
        haddr = 32'h50; hwrite = 1; hsel = 1;
        for (int i = 0; i < 6; i++) begin
            htrans = (i < 3) ? 2'b00 : 2'b01;
            @(posedge clk); #1;
            if (!hreadyout || hresp || psel) seen = 1;
        end
        hsel = 0; htrans = 2'b10;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (!hreadyout || hresp || psel) seen = 1; end
        htrans = 0; hwrite = 0;
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL idle_busy_nosel: got activity %b want 0", seen); end
    endtask

    task automatic test_write();
        int lows, setups, accs, sat; logic el, bad;
        xfer(32'h10, 1, 3'b010, 32'h1234_5678, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (lows !== 3) begin fails++; $display("FAIL wr_lows: got %0d want 3", lows); end
        tests++; if (setups !== 1 || accs !== 1) begin fails++; $display("FAIL wr_phases: setup %0d access %0d want 1 1", setups, accs); end
        tests++; if (sat !== 2) begin fails++; $display("FAIL wr_setup_at: got %0d want 2", sat); end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL wr_apb_fields: got bad=%b want 0", bad); end
        tests++; if (hresp !== 1'b0 || el !== 1'b0 || psel !== 1'b0) begin fails++; $display("FAIL wr_done: hresp %b err_lo %b psel %b want 0 0 0", hresp, el, psel); end
    endtask

    task automatic test_read_wait();
        int lows, setups, accs, sat; logic el, bad;
        prdata = 32'hDEAD_BEEF;
        xfer(32'h20, 0, 3'b010, 32'h0, 3, 0, lows, setups, accs, sat, el, bad);
        tests++; if (lows !== 6) begin fails++; $display("FAIL rd_lows: got %0d want 6", lows); end
        tests++; if (accs !== 4) begin fails++; $display("FAIL rd_access: got %0d want 4", accs); end
        tests++; if (hrdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_hrdata: got %h want deadbeef", hrdata); end
        tests++; if (hresp !== 1'b0 || bad !== 1'b0) begin fails++; $display("FAIL rd_status: hresp %b bad %b want 0 0", hresp, bad); end
    endtask

    task automatic test_slverr();
        int lows, setups, accs, sat; logic el, bad;
        xfer(32'h14, 1, 3'b010, 32'hA5A5_0001, 0, 1, lows, setups, accs, sat, el, bad);
        pslverr = 0;
        tests++; if (lows !== 4) begin fails++; $display("FAIL err_lows: got %0d want 4", lows); end
        tests++; if (el !== 1'b1 || hresp !== 1'b1) begin fails++; $display("FAIL err_hresp: err1 %b err2 %b want 1 1", el, hresp); end
        tests++; if (accs !== 1 || bad !== 1'b0 || psel !== 1'b0) begin fails++; $display("FAIL err_psel: access %0d bad %b psel %b want 1 0 0", accs, bad, psel); end
        tests++; if (hrdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL err_hrdata_hold: got %h want deadbeef", hrdata); end
    endtask

    task automatic test_timeout();
        int lows, setups, accs, sat; logic el, bad;
        prdata = 32'h0BAD_0BAD;
        xfer(32'h60, 0, 3'b010, 32'h0, 1000, 0, lows, setups, accs, sat, el, bad);
        tests++; if (accs !== 4) begin fails++; $display("FAIL to_access: got %0d want 4", accs); end
        tests++; if (lows !== 7 || el !== 1'b1 || hresp !== 1'b1) begin fails++; $display("FAIL to_error: lows %0d err1 %b err2 %b want 7 1 1", lows, el, hresp); end
        tests++; if (bad !== 1'b0 || hrdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL to_side: bad %b hrdata %h want 0 deadbeef", bad, hrdata); end
        prdata = 32'h1357_9BDF;
        xfer(32'h64, 0, 3'b010, 32'h0, 3, 0, lows, setups, accs, sat, el, bad);
        tests++; if (accs !== 4 || hresp !== 1'b0 || el !== 1'b0) begin fails++; $display("FAIL to_edge_ok: access %0d hresp %b err_lo %b want 4 0 0", accs, hresp, el); end
        tests++; if (hrdata !== 32'h1357_9BDF) begin fails++; $display("FAIL to_edge_data: got %h want 13579bdf", hrdata); end
    endtask

    task automatic test_back_to_back();
        int lows, setups, accs, sat; logic el, bad;
        prdata = 32'hCAFE_F00D;
        xfer(32'h24, 0, 3'b010, 32'h0, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (hrdata !== 32'hCAFE_F00D || lows !== 3) begin fails++; $display("FAIL b2b_read: hrdata %h lows %0d want cafef00d 3", hrdata, lows); end
        xfer(32'h28, 1, 3'b010, 32'h8765_4321, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (sat !== 2 || lows !== 3 || bad !== 1'b0) begin fails++; $display("FAIL b2b_write: setup_at %0d lows %0d bad %b want 2 3 0", sat, lows, bad); end
        tests++; if (hrdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_hold: got %h want cafef00d", hrdata); end
        xfer(32'h2C, 1, 3'b000, 32'h0000_00FF, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (setups + accs !== 0 || lows !== 1) begin fails++; $display("FAIL byte_nopsel: psel cycles %0d lows %0d want 0 1", setups + accs, lows); end
        tests++; if (el !== 1'b1 || hresp !== 1'b1) begin fails++; $display("FAIL byte_err: err1 %b err2 %b want 1 1", el, hresp); end
        xfer(32'h30, 1, 3'b010, 32'h0F0F_F0F0, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (sat !== 2 || hresp !== 1'b0 || bad !== 1'b0) begin fails++; $display("FAIL err2_accept: setup_at %0d hresp %b bad %b want 2 0 0", sat, hresp, bad); end
    endtask

    task automatic test_reset_mid();
        int n, lows, setups, accs, sat; logic el, bad;
        haddr = 32'h40; hwrite = 0; hsize = 3'b010; htrans = 2'b10; hsel = 1; pready = 0;
        @(posedge clk); #1;
        hsel = 0; htrans = 0; n = 0;
        while (!(psel && penable) && n < 10) begin @(posedge clk); #1; n++; end
        tests++; if (!(psel && penable)) begin fails++; $display("FAIL rmid_reach: psel %b penable %b want 1 1", psel, penable); end
        #3 reset = 1; #1;
        tests++; if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin fails++; $display("FAIL rmid_async: psel/penable/hreadyout/hresp %b want 0010", {psel, penable, hreadyout, hresp}); end
        tests++; if (hrdata !== 32'h0) begin fails++; $display("FAIL rmid_hrdata: got %h want 0", hrdata); end
        @(posedge clk); #1; reset = 0;
        xfer(32'h44, 1, 3'b010, 32'h5555_AAAA, 0, 0, lows, setups, accs, sat, el, bad);
        tests++; if (lows !== 3 || hresp !== 1'b0 || bad !== 1'b0 || accs !== 1) begin fails++; $display("FAIL rmid_after: lows %0d hresp %b bad %b access %0d want 3 0 0 1", lows, hresp, bad, accs); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        test_reset();
        test_idle_transfers();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hasti_to_poci_bridge.md
Name: hasti_to_poci_bridge

Overview:
- Bridges one HASTI (AHB-Lite) slave port onto one POCI (APB) master port.
- Sits downstream of the HASTI interconnect and upstream of the peripheral register blocks.
- Converts every accepted AHB transfer into one APB setup/access pair and returns read data or error.
- Adds a PREADY watchdog so a hung peripheral cannot lock the core bus.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in ACCESS waiting for pready. 0 disables the watchdog.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- ahb  modport if_hasti_slave_io.n  bundle  HASTI slave side. Uses haddr, hwrite, hsize, htrans, hwdata, hsel, hready; drives hrdata, hreadyout, hresp. hburst, hprot and hmastlock are ignored.
- apb  modport if_poci.n  bundle  POCI master side. Drives paddr, pwrite, psel, penable, pwdata; samples prdata, pready, pslverr.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset. All state and outputs are registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=OKAY, state=IDLE, watchdog=0.
- Accept condition: hsel & hready & htrans in {NONSEQ, SEQ} while the bridge is in an accepting state (IDLE, DONE, ERR2).
  - On accept: register haddr (truncated to pk_poci::addr_width LSBs), hwrite and hsize.
  - IDLE/BUSY transfers, or hsel=0, get a zero-wait OKAY and cause no APB activity.
- Unsupported size: an accepted write with hsize != WORD goes directly to ERR1. No APB access is issued. Reads of any size are performed as full-word APB reads.
- FSM:
  - IDLE: hreadyout=1, hresp=OKAY. Accept -> LATCH.
  - LATCH: hreadyout=0. Register hwdata into pwdata (writes only). Go to SETUP.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable. Go to ACCESS.
  - ACCESS: psel=1, penable=1, watchdog increments each cycle.
    - pready=1 & pslverr=0: capture prdata into hrdata (reads), then psel=0, penable=0 -> DONE.
    - pready=1 & pslverr=1: psel=0, penable=0 -> ERR1.
    - Watchdog reaches TIMEOUT_CYCLES with pready=0: drop psel/penable -> ERR1.
  - DONE: hreadyout=1, hresp=OKAY, hrdata valid for this one cycle. Accept -> LATCH, else -> IDLE.
  - ERR1: hreadyout=0, hresp=ERROR. Go to ERR2. This forms the mandatory two-cycle AHB error response.
  - ERR2: hreadyout=1, hresp=ERROR. Accept -> LATCH, else -> IDLE.
- Latency: minimum 4 cycles from address phase to data-phase completion (LATCH, SETUP, ACCESS, DONE) with zero-wait pready. Each pready wait state adds 1 cycle.
- Back-to-back: an address phase presented in DONE or ERR2 is accepted with no idle cycle. Its hwdata is taken in the following LATCH cycle.
- APB stability: paddr, pwrite and pwdata do not change from SETUP through the final ACCESS cycle. psel is never asserted outside SETUP/ACCESS.
- Watchdog: cleared on entry to SETUP. It never wraps, and a pready arriving in the timeout cycle itself has priority (normal completion).
- hrdata holds its last value outside DONE. Writes do not modify it.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). The in-flight AHB transfer is lost and no APB cycle completes.

Test Plan:
- Single write, 0x1234_5678 to haddr 0x0000_0010, pready=1 immediately -> one SETUP cycle then one ACCESS cycle with paddr=0x10, pwrite=1, pwdata=0x1234_5678; hreadyout low for 3 cycles; hresp=OKAY.
- Read from 0x20, prdata=0xDEAD_BEEF, pready held low for 3 ACCESS cycles -> hrdata=0xDEAD_BEEF in DONE; hreadyout low for 6 cycles total.
- Write with pslverr=1 -> hresp=ERROR for 2 cycles, hreadyout 0 then 1; psel deasserts after the error cycle.
- TIMEOUT_CYCLES=4, pready stuck at 0 -> exactly 4 ACCESS cycles, then psel=0 and a two-cycle ERROR response. Repeat with pready rising in the 4th cycle -> OKAY.
- Back-to-back read then write, with the second address phase issued in DONE -> second SETUP follows 2 cycles after DONE with no IDLE. Also issue a byte write (hsize=BYTE) -> ERROR with psel never asserted.
- Assert reset while in ACCESS -> psel=0, penable=0, hreadyout=1 in the same cycle. A next transfer after reset release completes normally.
